// File: rtl/x2c_pkt_drain_if.sv
// Write-side, read-side and statistics signals of the x2c packet drain controller.
// The controller attaches through the slave modport; the producer/consumer side through master.
interface x2c_pkt_drain_if #(
    parameter int DW = 256,
    parameter int CW = DW / 8
);
    logic [DW-1:0] data_in;
    logic [CW-1:0] ctrl_in;
    logic          x_we;
    logic [31:0]   x_byte_cnt;
    logic          x_bcnt_we;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic [CW-1:0] ctrl_out;
    logic          out_vld;
    logic          out_sof;
    logic          out_eof;
    logic [31:0]   pkt_cnt;
    logic [31:0]   drop_cnt;
    logic          ovf;

    modport slave (
        input  data_in, ctrl_in, x_we, x_byte_cnt, x_bcnt_we, out_ready,
        output data_out, ctrl_out, out_vld, out_sof, out_eof, pkt_cnt, drop_cnt, ovf
    );

    modport master (
        output data_in, ctrl_in, x_we, x_byte_cnt, x_bcnt_we, out_ready,
        input  data_out, ctrl_out, out_vld, out_sof, out_eof, pkt_cnt, drop_cnt, ovf
    );
endinterface

// File: rtl/x2c_pkt_drain.sv
// Byte-count-driven packet drain: buffers byte counts and data/ctrl words, then replays each
// packet as one sof/eof framed valid/ready burst, or discards it when its drop flag is set.
module x2c_pkt_drain #(
    parameter int         DW         = 256,
    parameter int         CW         = DW / 8,
    parameter int         BCNT_DEPTH = 256,
    parameter int         DATA_DEPTH = 1024,
    parameter logic [7:0] IDLE_BYTE  = 8'h07
) (
    input logic            x_clk,
    input logic            reset_,
    x2c_pkt_drain_if.slave bus
);
    localparam int BPW      = DW / 8;
    localparam int LOG2_BPW = $clog2(BPW);
    localparam int BAW      = $clog2(BCNT_DEPTH);
    localparam int DAW      = $clog2(DATA_DEPTH);

    typedef struct packed {
        logic          sof;
        logic          eof;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_POP    = 6'b000010,
        S_LOAD   = 6'b000100,
        S_STREAM = 6'b001000,
        S_DROP   = 6'b010000,
        S_DONE   = 6'b100000
    } state_t;

    // Byte-count FIFO: {drop, bcnt[15:0]} per packet
    logic [16:0]    r_bc_mem [BCNT_DEPTH];
    logic [BAW:0]   r_bc_wp;
    logic [BAW:0]   r_bc_rp;
    logic [16:0]    r_bc_q;

    logic [DW+CW-1:0] r_df_mem [DATA_DEPTH];
    logic [DAW:0]     r_df_wp;
    logic [DAW:0]     r_df_rp;

    beat_t       r_sk_mem [2];
    logic        r_sk_head;
    logic [1:0]  r_sk_cnt;

    state_t      r_state;
    logic [15:0] r_words_left;
    logic        r_first;
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_drop_cnt;
    logic        r_ovf;

    logic        w_bc_empty, w_bc_full, w_bc_pop, w_bc_push, w_bc_ovf;
    logic        w_df_empty, w_df_full, w_df_rd, w_df_push, w_df_ovf;
    logic        w_stream_rd, w_drop_rd;
    logic        w_out_vld, w_fire, w_sk_slot;
    beat_t       w_head, w_new;
    logic [15:0] w_bc_sum, w_wc;
    logic        w_unused_bcnt_hi;

    assign w_unused_bcnt_hi = ^bus.x_byte_cnt[31:17];

    assign w_bc_empty = (r_bc_wp == r_bc_rp);
    assign w_bc_full  = (r_bc_wp[BAW] != r_bc_rp[BAW]) && (r_bc_wp[BAW-1:0] == r_bc_rp[BAW-1:0]);
    assign w_bc_pop   = (r_state == S_POP);
    assign w_bc_push  = bus.x_bcnt_we && (!w_bc_full || w_bc_pop);
    assign w_bc_ovf   = bus.x_bcnt_we && w_bc_full && !w_bc_pop;

    assign w_df_empty = (r_df_wp == r_df_rp);
    assign w_df_full  = (r_df_wp[DAW] != r_df_rp[DAW]) && (r_df_wp[DAW-1:0] == r_df_rp[DAW-1:0]);
    assign w_df_push  = bus.x_we && (!w_df_full || w_df_rd);
    assign w_df_ovf   = bus.x_we && w_df_full && !w_df_rd;

    // Words per packet, deliberately in 16-bit arithmetic
    assign w_bc_sum = r_bc_q[15:0] + 16'(BPW - 1);
    assign w_wc     = w_bc_sum >> LOG2_BPW;

    assign w_out_vld = (r_sk_cnt != 2'd0);
    assign w_head    = r_sk_mem[r_sk_head];
    assign w_fire    = w_out_vld && bus.out_ready;
    assign w_sk_slot = r_sk_head ^ r_sk_cnt[0];

    // A word leaving this cycle frees the slot the new read lands in at the same edge
    assign w_stream_rd = (r_state == S_STREAM) && (r_words_left != 16'd0) && !w_df_empty &&
                         ((r_sk_cnt != 2'd2) || w_fire);
    assign w_drop_rd   = (r_state == S_DROP) && (r_words_left != 16'd0) && !w_df_empty;
    assign w_df_rd     = w_stream_rd || w_drop_rd;

    assign w_new = {r_first, (r_words_left == 16'd1), r_df_mem[r_df_rp[DAW-1:0]]};

    assign bus.out_vld  = w_out_vld;
    assign bus.data_out = w_out_vld ? w_head.data : {BPW{IDLE_BYTE}};
    assign bus.ctrl_out = w_out_vld ? w_head.ctrl : {CW{1'b1}};
    assign bus.out_sof  = w_out_vld && w_head.sof;
    assign bus.out_eof  = w_out_vld && w_head.eof;
    assign bus.pkt_cnt  = r_pkt_cnt;
    assign bus.drop_cnt = r_drop_cnt;
    assign bus.ovf      = r_ovf;

    // NOTE: storage arrays carry no reset; emptiness lives in the pointers and skid count,
    // so a reset clears contents logically without needing a resettable RAM.
    always_ff @(posedge x_clk) begin
        if (w_bc_push) r_bc_mem[r_bc_wp[BAW-1:0]] <= bus.x_byte_cnt[16:0];
        if (w_bc_pop)  r_bc_q <= r_bc_mem[r_bc_rp[BAW-1:0]];
        if (w_df_push) r_df_mem[r_df_wp[DAW-1:0]] <= {bus.ctrl_in, bus.data_in};
        if (w_stream_rd) r_sk_mem[w_sk_slot] <= w_new;
    end

    // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
    always_ff @(posedge x_clk or negedge reset_) begin
        if (!reset_) begin
            r_bc_wp      <= '0;
            r_bc_rp      <= '0;
            r_df_wp      <= '0;
            r_df_rp      <= '0;
            r_sk_head    <= 1'b0;
            r_sk_cnt     <= 2'd0;
            r_state      <= S_IDLE;
            r_words_left <= 16'd0;
            r_first      <= 1'b0;
            r_pkt_cnt    <= 32'd0;
            r_drop_cnt   <= 32'd0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_bc_push) r_bc_wp <= r_bc_wp + (BAW+1)'(1);
            if (w_bc_pop)  r_bc_rp <= r_bc_rp + (BAW+1)'(1);
            if (w_df_push) r_df_wp <= r_df_wp + (DAW+1)'(1);
            if (w_df_rd)   r_df_rp <= r_df_rp + (DAW+1)'(1);
            if (w_bc_ovf || w_df_ovf) r_ovf <= 1'b1;

            r_sk_cnt <= r_sk_cnt + 2'(w_stream_rd) - 2'(w_fire);
            if (w_fire) r_sk_head <= ~r_sk_head;
            if (w_fire && w_head.eof) r_pkt_cnt <= r_pkt_cnt + 32'd1;

            case (r_state)
                S_IDLE: if (!w_bc_empty) r_state <= S_POP;
                S_POP:  r_state <= S_LOAD;
                S_LOAD: begin
                    r_words_left <= w_wc;
                    r_first      <= 1'b1;
                    if (w_wc == 16'd0)  r_state <= S_DONE;
                    else if (r_bc_q[16]) r_state <= S_DROP;
                    else                 r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_stream_rd) begin
                        r_words_left <= r_words_left - 16'd1;
                        r_first      <= 1'b0;
                    end
                    if (w_fire && w_head.eof) r_state <= S_DONE;
                end
                S_DROP: begin
                    if (r_words_left == 16'd0) begin
                        r_drop_cnt <= r_drop_cnt + 32'd1;
                        r_state    <= S_DONE;
                    end else if (w_drop_rd) begin
                        r_words_left <= r_words_left - 16'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_x2c_pkt_drain.sv
// Directed bench for x2c_pkt_drain (DW=256): framing, stalls, drop, overflow and mid-packet reset.
module tb_x2c_pkt_drain;
    localparam int DW = 256;
    localparam int CW = 32;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          sof;
        logic          eof;
    } beat_t;

    logic x_clk = 1'b0;
    logic reset_;
    int   n_cmp = 0;
    int   n_bad = 0;
    beat_t q[$];

    always #5 x_clk = ~x_clk;

    x2c_pkt_drain_if #(.DW(DW), .CW(CW)) bus ();

    x2c_pkt_drain #(
        .DW(DW), .CW(CW), .BCNT_DEPTH(256), .DATA_DEPTH(1024), .IDLE_BYTE(8'h07)
    ) u_dut (
        .x_clk (x_clk),
        .reset_(reset_),
        .bus   (bus)
    );

    // Handshaken beats, sampled mid-cycle
    always @(negedge x_clk) begin
        if (reset_ === 1'b1 && bus.out_vld === 1'b1 && bus.out_ready === 1'b1)
            q.push_back('{bus.data_out, bus.ctrl_out, bus.out_sof, bus.out_eof});
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkw(input int p, input int i);
        logic [31:0] t;
        t = 32'(p * 65536 + i) ^ 32'h5A00_0000;
        return {8{t}};
    endfunction

    function automatic logic [CW-1:0] mkc(input int p, input int i);
        return 32'(p * 256 + i) ^ 32'hF0F0_0000;
    endfunction

    task automatic tick();
        @(posedge x_clk);
        #1;
    endtask

    task automatic push_word(input int p, input int i);
        bus.data_in = mkw(p, i);
        bus.ctrl_in = mkc(p, i);
        bus.x_we    = 1'b1;
        tick();
        bus.x_we    = 1'b0;
    endtask

    task automatic push_bcnt(input logic [31:0] v);
        bus.x_byte_cnt = v;
        bus.x_bcnt_we  = 1'b1;
        tick();
        bus.x_bcnt_we  = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int c = 0;
        while (q.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(tag, 256'(q.size()), 256'(n));
    endtask

    initial begin
        logic [DW-1:0] idle_word;
        logic          pat [6];
        int            idx [6];
        int            n;
        int            errs;

        idle_word      = {32{8'h07}};
        pat            = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        idx            = '{0, 1, 1, 1, 2, 2};
        reset_         = 1'b0;
        bus.data_in    = '0;
        bus.ctrl_in    = '0;
        bus.x_we       = 1'b0;
        bus.x_byte_cnt = '0;
        bus.x_bcnt_we  = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) tick();

        chk("rst_vld",  256'(bus.out_vld), 256'(0));
        chk("rst_data", 256'(bus.data_out), 256'(idle_word));
        chk("rst_ctrl", 256'(bus.ctrl_out), 256'(32'hFFFF_FFFF));
        chk("rst_pkt",  256'(bus.pkt_cnt), 256'(0));
        chk("rst_drop", 256'(bus.drop_cnt), 256'(0));
        chk("rst_ovf",  256'(bus.ovf), 256'(0));
        reset_ = 1'b1;
        repeat (2) tick();

        // 1: two full words, first-word latency
        push_word(1, 0);
        push_word(1, 1);
        push_bcnt(32'd64);
        n = 0;
        while (bus.out_vld !== 1'b1 && n < 20) begin
            @(negedge x_clk);
            n++;
        end
        chk("t1_latency", 256'(n - 1), 256'(4));
        wait_beats("t1_beats", 2, 20);
        chk("t1_d0",   q[0].d, mkw(1, 0));
        chk("t1_c0",   256'(q[0].c), 256'(mkc(1, 0)));
        chk("t1_sof0", 256'(q[0].sof), 256'(1));
        chk("t1_eof0", 256'(q[0].eof), 256'(0));
        chk("t1_d1",   q[1].d, mkw(1, 1));
        chk("t1_sof1", 256'(q[1].sof), 256'(0));
        chk("t1_eof1", 256'(q[1].eof), 256'(1));
        repeat (3) tick();
        chk("t1_pkt",  256'(bus.pkt_cnt), 256'(1));

        // 2: partial last word, then a single-word packet
        q.delete();
        push_word(2, 0);
        push_word(2, 1);
        push_bcnt(32'd33);
        push_word(3, 0);
        push_bcnt(32'd32);
        wait_beats("t2_beats", 3, 60);
        chk("t2_d0",   q[0].d, mkw(2, 0));
        chk("t2_sof0", 256'(q[0].sof), 256'(1));
        chk("t2_d1",   q[1].d, mkw(2, 1));
        chk("t2_eof1", 256'(q[1].eof), 256'(1));
        chk("t2_d2",   q[2].d, mkw(3, 0));
        chk("t2_sof2", 256'(q[2].sof), 256'(1));
        chk("t2_eof2", 256'(q[2].eof), 256'(1));
        repeat (3) tick();
        chk("t2_pkt",  256'(bus.pkt_cnt), 256'(3));

        // 3: back-pressure, output held stable while not ready
        q.delete();
        bus.out_ready = 1'b0;
        push_word(4, 0);
        push_word(4, 1);
        push_word(4, 2);
        push_bcnt(32'd96);
        n = 0;
        while (bus.out_vld !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("t3_vld", 256'(bus.out_vld), 256'(1));
        for (int i = 0; i < 6; i++) begin
            bus.out_ready = pat[i];
            chk($sformatf("t3_hold%0d", i), bus.data_out, mkw(4, idx[i]));
            tick();
        end
        bus.out_ready = 1'b1;
        wait_beats("t3_beats", 3, 20);
        for (int i = 0; i < 3; i++) chk($sformatf("t3_d%0d", i), q[i].d, mkw(4, i));
        chk("t3_sof0", 256'(q[0].sof), 256'(1));
        chk("t3_eof2", 256'(q[2].eof), 256'(1));

        // 4: dropped packet followed by a delivered one
        q.delete();
        push_word(5, 0);
        push_word(5, 1);
        push_bcnt(32'h0001_0040);
        push_word(6, 0);
        push_bcnt(32'd32);
        wait_beats("t4_beats", 1, 60);
        repeat (10) tick();
        chk("t4_only1", 256'(q.size()), 256'(1));
        chk("t4_d0",    q[0].d, mkw(6, 0));
        chk("t4_sofeof", 256'({q[0].sof, q[0].eof}), 256'(2'b11));
        chk("t4_drop",  256'(bus.drop_cnt), 256'(1));
        chk("t4_pkt",   256'(bus.pkt_cnt), 256'(5));

        // 5: overflow of the data FIFO; first 1024 words survive
        q.delete();
        for (int i = 0; i < 1025; i++) begin
            if (i == 1024) chk("t5_ovf_at_full", 256'(bus.ovf), 256'(0));
            bus.data_in = mkw(8, i);
            bus.ctrl_in = mkc(8, i);
            bus.x_we    = 1'b1;
            tick();
        end
        bus.x_we = 1'b0;
        chk("t5_ovf", 256'(bus.ovf), 256'(1));
        repeat (5) tick();
        chk("t5_ovf_sticky", 256'(bus.ovf), 256'(1));
        push_bcnt(32'd32768);
        wait_beats("t5_beats", 1024, 3000);
        errs = 0;
        for (int i = 0; i < q.size() && i < 1024; i++)
            if (q[i].d !== mkw(8, i) || q[i].c !== mkc(8, i)) errs++;
        chk("t5_word_errs", 256'(errs), 256'(0));
        if (q.size() >= 1024) begin
            chk("t5_sof", 256'(q[0].sof), 256'(1));
            chk("t5_eof", 256'(q[1023].eof), 256'(1));
        end
        repeat (10) tick();
        chk("t5_no_extra", 256'(q.size()), 256'(1024));
        chk("t5_pkt", 256'(bus.pkt_cnt), 256'(6));
        chk("t5_ovf_end", 256'(bus.ovf), 256'(1));

        // 6: reset while beat 2 of a 4-beat packet is presented
        q.delete();
        for (int i = 0; i < 4; i++) push_word(9, i);
        push_bcnt(32'd128);
        n = 0;
        while (q.size() < 1 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_beat1", 256'(q.size()), 256'(1));
        chk("t6_beat2_shown", bus.data_out, mkw(9, 1));
        reset_ = 1'b0;
        #1;
        chk("t6_vld",  256'(bus.out_vld), 256'(0));
        chk("t6_data", bus.data_out, idle_word);
        chk("t6_ctrl", 256'(bus.ctrl_out), 256'(32'hFFFF_FFFF));
        chk("t6_sofeof", 256'({bus.out_sof, bus.out_eof}), 256'(0));
        chk("t6_pkt",  256'(bus.pkt_cnt), 256'(0));
        chk("t6_ovf",  256'(bus.ovf), 256'(0));
        tick();
        tick();
        reset_ = 1'b1;
        q.delete();
        repeat (20) tick();
        chk("t6_quiet", 256'(q.size()), 256'(0));
        push_word(10, 0);
        push_bcnt(32'd32);
        wait_beats("t6_after", 1, 30);
        if (q.size() >= 1) begin
            chk("t6_after_d", q[0].d, mkw(10, 0));
            chk("t6_after_sofeof", 256'({q[0].sof, q[0].eof}), 256'(2'b11));
        end
        repeat (3) tick();
        chk("t6_after_pkt", 256'(bus.pkt_cnt), 256'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
